// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter feeding byte FIFOs into one UART transmitter
module uart_tx_arbiter #(
    parameter int NUM_CH    = 4,
    parameter int MAX_BURST = 16,
    parameter int HDR_EN    = 1
) (
    input  logic                  CLK288MHZ,
    input  logic                  reset,
    input  logic [NUM_CH-1:0]     chNE,
    input  logic [8*NUM_CH-1:0]   chData,
    input  logic [NUM_CH-1:0]     chMask,
    output logic [NUM_CH-1:0]     chRead,
    output logic [7:0]            txData,
    output logic                  txValid,
    input  logic                  txReadEn,
    output logic [2:0]            grantCh,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, HDR, DATA, SETTLE} state_t;

    state_t              state, state_n;
    logic [7:0]          burstCnt;
    logic [2:0]          rrPtr;
    logic [7:0]          ne_ext, mask_ext, elig;
    logic [63:0]         data_ext;
    logic [2:0]          pick;
    logic                any_elig;
    logic                burst_end;
    logic [NUM_CH-1:0]   read_onehot;

    // Widen channel inputs to 8 lanes so a 3-bit grant index always fits exactly.
    always_comb begin
        ne_ext   = '0;
        mask_ext = '0;
        data_ext = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            ne_ext[k]            = chNE[k];
            mask_ext[k]          = chMask[k];
            data_ext[8*k +: 8]   = chData[8*k +: 8];
        end
    end

    assign elig = ne_ext & mask_ext;

    // Scan from the farthest offset down so the nearest eligible channel after rrPtr wins.
    always_comb begin
        pick     = '0;
        any_elig = 1'b0;
        for (int i = NUM_CH; i >= 1; i--) begin
            int idx;
            idx = (int'(rrPtr) + i) % NUM_CH;
            if (elig[idx]) begin
                pick     = 3'(idx);
                any_elig = 1'b1;
            end
        end
    end

    always_comb begin
        read_onehot = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            read_onehot[k] = (grantCh == 3'(k));
        end
    end

    assign burst_end = (burstCnt == 8'(MAX_BURST)) || !ne_ext[grantCh] || !mask_ext[grantCh];

    always_ff @(posedge CLK288MHZ) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (any_elig) state_n = (HDR_EN != 0) ? HDR : DATA;
            HDR:     if (txReadEn) state_n = DATA;
            DATA:    if (txReadEn) state_n = SETTLE;
            SETTLE:  state_n = burst_end ? IDLE : DATA;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK288MHZ) begin
        if (reset) begin
            chRead   <= '0;
            grantCh  <= '0;
            burstCnt <= '0;
            rrPtr    <= 3'(NUM_CH - 1);
            busy     <= 1'b0;
        end else begin
            chRead <= '0;
            busy   <= (state_n != IDLE);
            case (state)
                IDLE: begin
                    if (any_elig) begin
                        grantCh  <= pick;
                        burstCnt <= '0;
                    end
                end
                DATA: begin
                    if (txReadEn) begin
                        chRead   <= read_onehot;
                        burstCnt <= burstCnt + 8'd1;
                    end
                end
                SETTLE: begin
                    if (burst_end) rrPtr <= grantCh;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        txData  = 8'h00;
        txValid = 1'b0;
        case (state)
            HDR: begin
                txData  = 8'hA0 | {5'b00000, grantCh};
                txValid = 1'b1;
            end
            DATA: begin
                txData  = data_ext[{grantCh, 3'b000} +: 8];
                txValid = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed bench for uart_tx_arbiter with header and headerless instances
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  ne [2];
    logic [3:0]  mask [2];
    logic [3:0]  rd [2];
    logic [31:0] data [2];
    logic [7:0]  txd [2];
    logic        txv [2];
    logic        ren [2];
    logic [2:0]  gch [2];
    logic        busy [2];

    logic [7:0]  mem [2][4][16];
    int          cnt [2][4];
    int          rp [2][4];
    int          pops [2][4];
    logic        tx_en [2];
    logic        multi_hot [2];
    logic [7:0]  log_a [$];
    logic [7:0]  log_b [$];
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_CH(4), .MAX_BURST(4), .HDR_EN(1)) u_a (
        .CLK288MHZ(clk), .reset(reset), .chNE(ne[0]), .chData(data[0]), .chMask(mask[0]),
        .chRead(rd[0]), .txData(txd[0]), .txValid(txv[0]), .txReadEn(ren[0]),
        .grantCh(gch[0]), .busy(busy[0])
    );

    uart_tx_arbiter #(.NUM_CH(4), .MAX_BURST(16), .HDR_EN(0)) u_b (
        .CLK288MHZ(clk), .reset(reset), .chNE(ne[1]), .chData(data[1]), .chMask(mask[1]),
        .chRead(rd[1]), .txData(txd[1]), .txValid(txv[1]), .txReadEn(ren[1]),
        .grantCh(gch[1]), .busy(busy[1])
    );

    always_comb begin
        for (int d = 0; d < 2; d++) begin
            ne[d]   = '0;
            data[d] = '0;
            for (int k = 0; k < 4; k++) begin
                ne[d][k]          = (cnt[d][k] > 0);
                data[d][8*k +: 8] = mem[d][k][rp[d][k]];
            end
        end
    end

    // FIFO model pops mid-cycle while chRead is high, so flags are settled by the next edge.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if ($countones(rd[d]) > 1) multi_hot[d] = 1'b1;
            for (int k = 0; k < 4; k++) begin
                if (rd[d][k]) begin
                    pops[d][k]++;
                    if (cnt[d][k] > 0) begin
                        rp[d][k] = (rp[d][k] + 1) % 16;
                        cnt[d][k]--;
                    end
                end
            end
            if (tx_en[d]) begin
                if (txv[d]) begin
                    if (d == 0) log_a.push_back(txd[d]);
                    else        log_b.push_back(txd[d]);
                    ren[d] = 1'b1;
                end else begin
                    ren[d] = 1'b0;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input int d, input int k, input logic [7:0] v);
        mem[d][k][(rp[d][k] + cnt[d][k]) % 16] = v;
        cnt[d][k]++;
    endtask

    task automatic clear_stats();
        log_a.delete();
        log_b.delete();
        for (int d = 0; d < 2; d++)
            for (int k = 0; k < 4; k++) pops[d][k] = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_log(input int d, input int n, input string tag);
        int t = 0;
        while (((d == 0) ? log_a.size() : log_b.size()) < n && t < 500) begin
            @(negedge clk);
            t++;
        end
        repeat (4) @(negedge clk);
        check(tag, (d == 0) ? log_a.size() : log_b.size(), n);
    endtask

    task automatic wait_drain(input int d, input string tag);
        int t = 0;
        while ((busy[d] || cnt[d][0] + cnt[d][1] + cnt[d][2] + cnt[d][3] != 0) && t < 500) begin
            @(negedge clk);
            t++;
        end
        check(tag, (t < 500), 1);
    endtask

    task automatic cmp_log(input int d, input string tag, input logic [7:0] exp[$]);
        for (int i = 0; i < exp.size(); i++) begin
            logic [7:0] got;
            if (d == 0) got = (i < log_a.size()) ? log_a[i] : 8'hxx;
            else        got = (i < log_b.size()) ? log_b[i] : 8'hxx;
            check($sformatf("%s[%0d]", tag, i), got, exp[i]);
        end
    endtask

    initial begin
        logic [7:0] exp[$];
        for (int d = 0; d < 2; d++) begin
            tx_en[d] = 1'b0; ren[d] = 1'b0; mask[d] = 4'hF; multi_hot[d] = 1'b0;
            for (int k = 0; k < 4; k++) begin
                cnt[d][k] = 0; rp[d][k] = 0; pops[d][k] = 0;
                for (int j = 0; j < 16; j++) mem[d][k][j] = 8'h00;
            end
        end
        repeat (2) @(negedge clk);
        check("rst_txv", txv[0], 0);
        check("rst_txd", txd[0], 8'h00);
        check("rst_gch", gch[0], 0);
        check("rst_busy", busy[0], 0);
        check("rst_rd", rd[0], 4'h0);
        check("rst_rrptr", u_a.rrPtr, 3);
        check("rst_burstcnt", u_a.burstCnt, 0);
        reset = 1'b0;

        // Single channel, one-cycle grant latency
        clear_stats();
        tx_en[0] = 1'b1;
        @(negedge clk);
        push(0, 2, 8'h11); push(0, 2, 8'h22); push(0, 2, 8'h33);
        @(negedge clk);
        check("t1_latency_txv", txv[0], 1);
        check("t1_latency_txd", txd[0], 8'hA2);
        wait_log(0, 4, "t1_len");
        exp = '{8'hA2, 8'h11, 8'h22, 8'h33};
        cmp_log(0, "t1_byte", exp);
        check("t1_pops2", pops[0][2], 3);
        check("t1_idle", busy[0], 0);
        check("t1_rrptr", u_a.rrPtr, 2);

        // Round robin between ch0 and ch3
        do_reset();
        clear_stats();
        push(0, 0, 8'h01); push(0, 0, 8'h02);
        push(0, 3, 8'h31); push(0, 3, 8'h32);
        wait_log(0, 6, "t2_len");
        exp = '{8'hA0, 8'h01, 8'h02, 8'hA3, 8'h31, 8'h32};
        cmp_log(0, "t2_byte", exp);
        check("t2_pops0", pops[0][0], 2);
        check("t2_pops3", pops[0][3], 2);

        // Burst limit of 4 with re-grant of a lone channel
        clear_stats();
        for (int i = 0; i < 10; i++) push(0, 1, 8'h40 + 8'(i));
        wait_log(0, 13, "t3_len");
        exp = '{8'hA1, 8'h40, 8'h41, 8'h42, 8'h43, 8'hA1, 8'h44, 8'h45, 8'h46, 8'h47,
                8'hA1, 8'h48, 8'h49};
        cmp_log(0, "t3_byte", exp);
        check("t3_pops1", pops[0][1], 10);

        // Masking keeps ch0 out until its mask bit returns
        clear_stats();
        mask[0] = 4'b0010;
        push(0, 0, 8'h50); push(0, 0, 8'h51); push(0, 1, 8'h60);
        wait_log(0, 2, "t4_len_masked");
        check("t4_idle_masked", busy[0], 0);
        mask[0] = 4'b0011;
        @(negedge clk);
        check("t4_unmask_txv", txv[0], 1);
        check("t4_unmask_txd", txd[0], 8'hA0);
        wait_log(0, 5, "t4_len");
        exp = '{8'hA1, 8'h60, 8'hA0, 8'h50, 8'h51};
        cmp_log(0, "t4_byte", exp);
        mask[0] = 4'hF;

        // Reset one cycle before the second payload byte is consumed
        tx_en[0] = 1'b0;
        ren[0] = 1'b0;
        do_reset();
        clear_stats();
        push(0, 1, 8'h70); push(0, 1, 8'h71); push(0, 1, 8'h72);
        @(negedge clk);
        check("t5_hdr", txd[0], 8'hA1);
        ren[0] = 1'b1;
        @(negedge clk);
        check("t5_b1", txd[0], 8'h70);
        ren[0] = 1'b1;
        @(negedge clk);
        ren[0] = 1'b0;
        @(negedge clk);
        check("t5_b2", txd[0], 8'h71);
        check("t5_rd_pre", rd[0], 4'h0);
        reset = 1'b1;
        push(0, 0, 8'h80);
        @(negedge clk);
        check("t5_rd_rst", rd[0], 4'h0);
        check("t5_txv_rst", txv[0], 0);
        check("t5_busy_rst", busy[0], 0);
        reset = 1'b0;
        ren[0] = 1'b1;
        @(negedge clk);
        check("t5_rd_after", rd[0], 4'h0);
        check("t5_regrant_txv", txv[0], 1);
        check("t5_regrant_txd", txd[0], 8'hA0);
        check("t5_regrant_gch", gch[0], 0);
        check("t5_pops1", pops[0][1], 1);
        ren[0] = 1'b0;
        tx_en[0] = 1'b1;
        wait_drain(0, "t5_drain");

        // Headerless instance, stray txReadEn while idle
        ren[1] = 1'b1;
        @(negedge clk);
        check("t6_stray_rd0", rd[1], 4'h0);
        @(negedge clk);
        check("t6_stray_rd1", rd[1], 4'h0);
        check("t6_stray_busy", busy[1], 0);
        ren[1] = 1'b0;
        tx_en[1] = 1'b1;
        push(1, 3, 8'h55); push(1, 3, 8'h66);
        @(negedge clk);
        check("t6_latency_txv", txv[1], 1);
        check("t6_latency_txd", txd[1], 8'h55);
        wait_log(1, 2, "t6_len");
        exp = '{8'h55, 8'h66};
        cmp_log(1, "t6_byte", exp);
        check("t6_pops3", pops[1][3], 2);

        check("onehot_a", multi_hot[0], 0);
        check("onehot_b", multi_hot[1], 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
- REQ-001: Parameter NUM_CH, default 4, number of requesting byte FIFOs (2..8).
- REQ-002: Parameter MAX_BURST, default 16, maximum payload bytes per grant (1..255).
- REQ-003: Parameter HDR_EN, default 1, when 1 each burst is prefixed by a channel-ID header byte.
- REQ-004: CLK288MHZ  input  1  sole clock; all state updates on rising edge.
- REQ-005: reset  input  1  synchronous, active-high reset.
- REQ-006: chNE  input  NUM_CH  per-channel FIFO not-empty.
- REQ-007: chData  input  8*NUM_CH  per-channel FIFO head byte; channel k on bits [8k+7:8k].
- REQ-008: chMask  input  NUM_CH  1 = channel eligible for grant.
- REQ-009: chRead  output  NUM_CH  one-cycle pop pulse to the granted FIFO.
- REQ-010: txData  output  8  byte presented to the UART transmitter dataIn.
- REQ-011: txValid  output  1  drives transmitter fifoNE; byte on txData is valid.
- REQ-012: txReadEn  input  1  transmitter readEn; one-cycle pulse, byte consumed.
- REQ-013: grantCh  output  3  index of the currently granted channel.
- REQ-014: busy  output  1  high in every state except IDLE.

Function
- REQ-015: The FSM SHALL have states IDLE, HDR, DATA, SETTLE; all outputs registered except txData and txValid, which are decoded from state and registers.
- REQ-016: IDLE: txValid=0; if any chNE&chMask bit is set, grant the first eligible channel searching upward from (rrPtr+1) mod NUM_CH with wrap, latch it into grantCh, clear burstCnt, go to HDR if HDR_EN else DATA.
- REQ-017: HDR: txData = 8'hA0 | grantCh, txValid=1; on txReadEn go to DATA with no pop.
- REQ-018: DATA: txData = chData byte of grantCh, txValid=1; txData SHALL remain stable until txReadEn.
- REQ-019: DATA with txReadEn: chRead[grantCh] pulses high exactly the next cycle, burstCnt increments, state goes to SETTLE.
- REQ-020: SETTLE (one cycle, txValid=0, lets FIFO flags update): if burstCnt==MAX_BURST, or chNE[grantCh]==0, or chMask[grantCh]==0, set rrPtr=grantCh and go to IDLE; else go to DATA.
- REQ-021: Grant-to-txValid latency SHALL be one cycle (IDLE decision cycle, then HDR/DATA asserts txValid).
- REQ-022: At most one chRead bit SHALL be high in any cycle; chRead SHALL never pulse for a header byte.
- REQ-023: txReadEn in IDLE or SETTLE SHALL be ignored (no pop, no state change).
- REQ-024: chMask deasserted for the granted channel mid-burst SHALL not abort the byte in flight; the burst ends at the next SETTLE.
- REQ-025: The granted FIFO is popped only by this block; chNE[grantCh] SHALL be treated as stable while in DATA.
- REQ-026: burstCnt SHALL be 8 bits and never exceed MAX_BURST.
- REQ-027: A channel that alone remains eligible SHALL be re-granted immediately after its burst (new header emitted).

Reset
- REQ-028: On reset, state=IDLE, chRead=0, txValid=0, txData=8'h00, grantCh=0, busy=0, burstCnt=0, rrPtr=NUM_CH-1 (channel 0 first priority).
- REQ-029: Reset asserted mid-burst SHALL abandon the burst without issuing a pop in the reset cycle or the following cycle.

Verification
- REQ-030: Single channel: ch2 holds 3 bytes 11,22,33, mask=F -> transmitter sees A2,11,22,33; chRead[2] pulses 3 times; returns to IDLE with rrPtr=2.
- REQ-031: Round robin: ch0 and ch3 each hold 2 bytes after reset -> order A0,x,x,A3,x,x; ch3 pending while ch0 served is not starved.
- REQ-032: Burst limit: MAX_BURST=4, ch1 holds 10 bytes, others empty -> A1+4 bytes, A1+4 bytes, A1+2 bytes; exactly 10 chRead[1] pulses.
- REQ-033: Masking: ch0 and ch1 non-empty, chMask=4'b0010 -> only ch1 granted; ch0 granted within one cycle of IDLE after mask set to 4'b0011.
- REQ-034: Reset mid-DATA: assert reset one cycle before txReadEn of byte 2 -> no chRead pulse, txValid=0, busy=0, next grant after release goes to ch0 if eligible.
- REQ-035: HDR_EN=0: ch3 holds 55,66 -> transmitter sees only 55,66; stray txReadEn in IDLE produces no chRead.
